// File: rtl/vote_tally_param.sv
// vote_tally_param: collects one-hot ballots, counts malformed ones, then scans the
// per-candidate tallies one per cycle to find the winner, its count and any tie.
module vote_tally_param #(
  parameter  int NUM_CAND  = 8,
  parameter  int NUM_VOTES = 8,
  localparam int CNT_W     = $clog2(NUM_VOTES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                ballot_vld,
  input  logic [NUM_CAND-1:0] ballot,
  output logic                ballot_rdy,
  output logic                busy,
  output logic                done,
  output logic [NUM_CAND-1:0] winner,
  output logic [CNT_W-1:0]    win_count,
  output logic                tie,
  output logic [7:0]          invalid_cnt
);

  localparam int IDX_W = $clog2(NUM_CAND + 1);
  localparam int SEL_W = $clog2(NUM_CAND);
  // scan index one past the last candidate marks the result-load cycle
  localparam logic [IDX_W-1:0] LOAD_IDX  = IDX_W'(NUM_CAND);
  localparam logic [CNT_W-1:0] FINAL_ACC = CNT_W'(NUM_VOTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_RESOLVE,
    ST_DONE
  } state_t;

  state_t              state_reg;
  logic                ballot_rdy_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [NUM_CAND-1:0] winner_reg;
  logic [CNT_W-1:0]    win_count_reg;
  logic                tie_reg;
  logic [7:0]          invalid_cnt_reg;
  logic [CNT_W-1:0]    accepted_reg;
  logic [IDX_W-1:0]    scan_idx_reg;
  logic [SEL_W-1:0]    lead_idx_reg;
  logic [CNT_W-1:0]    lead_cnt_reg;
  logic                lead_tie_reg;

  logic [NUM_CAND-1:0][CNT_W-1:0] tally;
  logic [CNT_W-1:0]               scan_cnt;
  logic [NUM_CAND-1:0]            ballot_less1;
  logic                           ballot_onehot;
  logic                           fire;
  logic                           accept;
  logic                           reject;
  logic                           clear;

  // one-hot test: nonzero and clearing the lowest set bit leaves nothing
  assign ballot_less1  = ballot - NUM_CAND'(1);
  assign ballot_onehot = (ballot != '0) && ((ballot & ballot_less1) == '0);
  assign fire          = ballot_vld && ballot_rdy_reg;
  assign accept        = fire && ballot_onehot;
  assign reject        = fire && !ballot_onehot;
  assign clear         = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CAND; gi++) begin : g_tally
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (clear) begin
          cnt_reg <= '0;
        end else if (accept && ballot[gi]) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign tally[gi] = cnt_reg;
    end
  endgenerate

  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (scan_idx_reg == IDX_W'(i)) begin
        scan_cnt = tally[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      invalid_cnt_reg <= '0;
    end else if (clear) begin
      invalid_cnt_reg <= '0;
    end else if (reject && (invalid_cnt_reg != 8'hFF)) begin
      invalid_cnt_reg <= invalid_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      ballot_rdy_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      winner_reg     <= '0;
      win_count_reg  <= '0;
      tie_reg        <= 1'b0;
      accepted_reg   <= '0;
      scan_idx_reg   <= '0;
      lead_idx_reg   <= '0;
      lead_cnt_reg   <= '0;
      lead_tie_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg      <= ST_COLLECT;
            ballot_rdy_reg <= 1'b1;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
            winner_reg     <= '0;
            win_count_reg  <= '0;
            tie_reg        <= 1'b0;
            accepted_reg   <= '0;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            accepted_reg <= accepted_reg + CNT_W'(1);
            if (accepted_reg == FINAL_ACC) begin
              state_reg      <= ST_RESOLVE;
              ballot_rdy_reg <= 1'b0;
              scan_idx_reg   <= '0;
              lead_idx_reg   <= '0;
              lead_cnt_reg   <= '0;
              lead_tie_reg   <= 1'b0;
            end
          end
        end
        ST_RESOLVE: begin
          if (scan_idx_reg == LOAD_IDX) begin
            state_reg     <= ST_DONE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            winner_reg    <= NUM_CAND'(1) << lead_idx_reg;
            win_count_reg <= lead_cnt_reg;
            tie_reg       <= lead_tie_reg;
          end else begin
            // strict greater wins so the lowest index keeps a tied lead
            if (scan_cnt > lead_cnt_reg) begin
              lead_cnt_reg <= scan_cnt;
              lead_idx_reg <= scan_idx_reg[SEL_W-1:0];
              lead_tie_reg <= 1'b0;
            end else if ((scan_cnt == lead_cnt_reg) && (scan_cnt != '0)) begin
              lead_tie_reg <= 1'b1;
            end
            scan_idx_reg <= scan_idx_reg + IDX_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ballot_rdy  = ballot_rdy_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign winner      = winner_reg;
  assign win_count   = win_count_reg;
  assign tie         = tie_reg;
  assign invalid_cnt = invalid_cnt_reg;

endmodule

// File: tb/tb_vote_tally_param.sv
// Directed bench for vote_tally_param: an 8x8 instance driven from a vector table plus
// hand-written reset/re-arm sequences, and a 16-candidate/20-vote instance.
module tb_vote_tally_param;

  localparam int NC_A = 8;
  localparam int NV_A = 8;
  localparam int CW_A = $clog2(NV_A + 1);
  localparam int NC_B = 16;
  localparam int NV_B = 20;
  localparam int CW_B = $clog2(NV_B + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            a_start = 1'b0;
  logic            a_vld = 1'b0;
  logic [NC_A-1:0] a_ballot = '0;
  logic            a_rdy, a_busy, a_done, a_tie;
  logic [NC_A-1:0] a_winner;
  logic [CW_A-1:0] a_wc;
  logic [7:0]      a_inv;

  logic            b_start = 1'b0;
  logic            b_vld = 1'b0;
  logic [NC_B-1:0] b_ballot = '0;
  logic            b_rdy, b_busy, b_done, b_tie;
  logic [NC_B-1:0] b_winner;
  logic [CW_B-1:0] b_wc;
  logic [7:0]      b_inv;

  vote_tally_param #(.NUM_CAND(NC_A), .NUM_VOTES(NV_A)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .ballot_vld(a_vld), .ballot(a_ballot),
    .ballot_rdy(a_rdy), .busy(a_busy), .done(a_done), .winner(a_winner),
    .win_count(a_wc), .tie(a_tie), .invalid_cnt(a_inv)
  );

  vote_tally_param #(.NUM_CAND(NC_B), .NUM_VOTES(NV_B)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .ballot_vld(b_vld), .ballot(b_ballot),
    .ballot_rdy(b_rdy), .busy(b_busy), .done(b_done), .winner(b_winner),
    .win_count(b_wc), .tie(b_tie), .invalid_cnt(b_inv)
  );

  typedef struct {
    logic [31:0] rdy, busy, done, win, wc, tie, inv;
  } obs_t;

  typedef struct {
    string       name;
    int          n;
    logic [87:0] bl;    // ballots in reading order, first ballot in the top byte used
    logic [31:0] w;
    logic [31:0] cnt;
    logic [31:0] t;
    logic [31:0] inv;
    int          hs;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int hs = 0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  function automatic obs_t obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.rdy = 32'(a_rdy); o.busy = 32'(a_busy); o.done = 32'(a_done);
      o.win = 32'(a_winner); o.wc = 32'(a_wc); o.tie = 32'(a_tie); o.inv = 32'(a_inv);
    end else begin
      o.rdy = 32'(b_rdy); o.busy = 32'(b_busy); o.done = 32'(b_done);
      o.win = 32'(b_winner); o.wc = 32'(b_wc); o.tie = 32'(b_tie); o.inv = 32'(b_inv);
    end
    return o;
  endfunction

  function automatic logic rdy_of(input int d);
    return (d == 0) ? a_rdy : b_rdy;
  endfunction

  function automatic logic done_of(input int d);
    return (d == 0) ? a_done : b_done;
  endfunction

  task automatic do_start(input int d);
    if (d == 0) a_start = 1'b1; else b_start = 1'b1;
    step();
    a_start = 1'b0;
    b_start = 1'b0;
    hs = 0;
  endtask

  task automatic feed(input int d, input logic [15:0] b);
    int guard;
    guard = 0;
    if (d == 0) begin a_ballot = b[7:0]; a_vld = 1'b1; end
    else begin b_ballot = b; b_vld = 1'b1; end
    while (!rdy_of(d) && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) begin
      n_vec++;
      n_bad++;
      $display("FAIL feed_timeout: ballot_rdy=0 for 20 cycles, required 1");
    end else begin
      hs++;
      step();
    end
    a_vld = 1'b0;
    b_vld = 1'b0;
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (!done_of(d) && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic check_res(input int d, input string tag, input logic [31:0] w,
                           input logic [31:0] c, input logic [31:0] t, input logic [31:0] inv);
    obs_t o;
    o = obs(d);
    check({tag, ".done"}, o.done, 32'd1);
    check({tag, ".winner"}, o.win, w);
    check({tag, ".win_count"}, o.wc, c);
    check({tag, ".tie"}, o.tie, t);
    check({tag, ".invalid_cnt"}, o.inv, inv);
  endtask

  task automatic check_zero(input int d, input string tag);
    obs_t o;
    o = obs(d);
    check({tag, ".rdy"}, o.rdy, 32'd0);
    check({tag, ".busy"}, o.busy, 32'd0);
    check({tag, ".done"}, o.done, 32'd0);
    check({tag, ".winner"}, o.win, 32'd0);
    check({tag, ".win_count"}, o.wc, 32'd0);
    check({tag, ".tie"}, o.tie, 32'd0);
    check({tag, ".invalid_cnt"}, o.inv, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    obs_t        o;
    logic [87:0] bl_v;
    logic [7:0]  b8;
    int          lat;

    vecs[0] = '{"T1",  8, 88'h04040104_80040201, 32'h04, 32'd4, 32'd0, 32'd0, 8};
    vecs[1] = '{"T2", 11, 88'h00101003_1010FF10_101010, 32'h10, 32'd8, 32'd0, 32'd3, 11};
    vecs[2] = '{"T3",  8, 88'h20202020_02020202, 32'h02, 32'd4, 32'd1, 32'd0, 8};
    vecs[3] = '{"TOP", 8, 88'h80808080_80808080, 32'h80, 32'd8, 32'd0, 32'd0, 8};
    vecs[4] = '{"TIE2", 8, 88'h01800108_80018008, 32'h01, 32'd3, 32'd1, 32'd0, 8};
    vecs[5] = '{"UNTIE", 8, 88'h01010202_04040408, 32'h04, 32'd3, 32'd0, 32'd0, 8};

    // reset state
    step();
    check_zero(0, "RST_A");
    check_zero(1, "RST_B");
    rst = 1'b1;
    step();

    // table-driven elections, first from IDLE, the rest re-armed from DONE
    for (int e = 0; e < 6; e++) begin
      do_start(0);
      bl_v = vecs[e].bl;
      for (int k = 0; k < vecs[e].n; k++) begin
        b8 = bl_v[8*(vecs[e].n-1-k) +: 8];
        feed(0, 16'(b8));
      end
      o = obs(0);
      check({vecs[e].name, ".rdy_after_last"}, o.rdy, 32'd0);
      check({vecs[e].name, ".busy_resolve"}, o.busy, 32'd1);
      wait_done(0, lat);
      check({vecs[e].name, ".latency"}, 32'(lat), 32'(NC_A + 1));
      check({vecs[e].name, ".handshakes"}, 32'(hs), 32'(vecs[e].hs));
      check_res(0, vecs[e].name, vecs[e].w, vecs[e].cnt, vecs[e].t, vecs[e].inv);
    end

    // T4: reset mid-collection discards the partial tally
    do_start(0);
    repeat (5) feed(0, 16'h0001);
    feed(0, 16'h00FF);
    check("T4.busy_before_rst", obs(0).busy, 32'd1);
    rst = 1'b0;
    #1;
    check_zero(0, "T4.in_rst");
    step();
    rst = 1'b1;
    a_vld = 1'b1;
    a_ballot = 8'hFF;
    step();
    step();
    a_vld = 1'b0;
    check_zero(0, "T4.idle_vld");
    do_start(0);
    repeat (8) feed(0, 16'h0001);
    wait_done(0, lat);
    check("T4.latency", 32'(lat), 32'(NC_A + 1));
    check_res(0, "T4", 32'h01, 32'd8, 32'd0, 32'd0);

    // T5: start ignored in COLLECT and RESOLVE, honoured in DONE
    do_start(0);
    repeat (4) feed(0, 16'h0008);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    o = obs(0);
    check("T5.collect_busy", o.busy, 32'd1);
    check("T5.collect_rdy", o.rdy, 32'd1);
    repeat (4) feed(0, 16'h0040);
    step();
    step();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    o = obs(0);
    check("T5.resolve_busy", o.busy, 32'd1);
    check("T5.resolve_done", o.done, 32'd0);
    wait_done(0, lat);
    check("T5.latency", 32'(lat + 3), 32'(NC_A + 1));
    check_res(0, "T5a", 32'h08, 32'd4, 32'd1, 32'd0);
    a_vld = 1'b1;
    a_ballot = 8'hFF;
    repeat (3) step();
    a_vld = 1'b0;
    check_res(0, "T5.hold", 32'h08, 32'd4, 32'd1, 32'd0);
    do_start(0);
    o = obs(0);
    check("T5.rearm_done", o.done, 32'd0);
    check("T5.rearm_busy", o.busy, 32'd1);
    check("T5.rearm_rdy", o.rdy, 32'd1);
    check("T5.rearm_winner", o.win, 32'd0);
    check("T5.rearm_wc", o.wc, 32'd0);
    check("T5.rearm_tie", o.tie, 32'd0);
    feed(0, 16'h0000);
    repeat (8) feed(0, 16'h0080);
    wait_done(0, lat);
    check("T5b.latency", 32'(lat), 32'(NC_A + 1));
    check_res(0, "T5b", 32'h80, 32'd8, 32'd0, 32'd1);

    // T6: 16 candidates, 20 votes
    do_start(1);
    repeat (12) feed(1, 16'h8000);
    repeat (8) feed(1, 16'h0008);
    wait_done(1, lat);
    check("T6.latency", 32'(lat), 32'(NC_B + 1));
    check_res(1, "T6", 32'h8000, 32'd12, 32'd0, 32'd0);
    do_start(1);
    repeat (20) feed(1, 16'h0001);
    wait_done(1, lat);
    check("T6b.latency", 32'(lat), 32'(NC_B + 1));
    check_res(1, "T6b", 32'h0001, 32'd20, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
